plab5_mcore_mem_net_resp_ser: RTL

Buffered, flow-controlled adapter that turns full-cacheline or single-word memory responses from a bank into a sequence of network flits. Each flit carries one data word, and control and data are kept on separately labelled buses. It sits between a cache/memory bank response port and the response network, replacing the combinational message packer where bursts, backpressure or per-response security domains are needed.

---
 rtl/plab5_mcore_mem_net_resp_ser.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/plab5_mcore_mem_net_resp_ser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : plab5_mcore_mem_net_resp_ser                                   |
// | Brief   : Buffered serializer turning bank responses into one-word flits |
// |           Optional: PLAB5_MCORE_MEM_NET_RESP_SCRUB_EN (failed -> 1 flit) |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module plab5_mcore_mem_net_resp_ser #(
  parameter int p_net_src           = 0,
  parameter int p_num_ports         = 4,
  parameter int p_mem_opaque_nbits  = 8,
  parameter int p_data_nbits        = 32,
  parameter int p_cacheline_nwords  = 4,
  parameter int p_net_opaque_nbits  = 4,
  parameter int p_net_srcdest_nbits = 3,
  parameter int p_buf_depth         = 2
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          mem_resp_val,
  output logic                                          mem_resp_rdy,
  input  logic                                          mem_resp_domain,
  input  logic                                          mem_resp_burst,
  input  logic [3+p_mem_opaque_nbits+2-1:0]             mem_resp_control,
  input  logic                                          mem_resp_fail,
  input  logic [p_cacheline_nwords*p_data_nbits-1:0]    mem_resp_data,
  output logic                                          net_msg_val,
  input  logic                                          net_msg_rdy,
  output logic                                          net_msg_domain,
  output logic [2*p_net_srcdest_nbits+p_net_opaque_nbits+3+3+p_mem_opaque_nbits+2-1:0] net_msg_control,
  output logic [p_data_nbits-1:0]                       net_msg_data
);

  localparam int c_CN      = 3 + p_mem_opaque_nbits + 2;
  localparam int c_LINE    = p_cacheline_nwords * p_data_nbits;
  localparam int c_IW      = $clog2(p_cacheline_nwords);
  localparam int c_PW      = (p_buf_depth > 1) ? $clog2(p_buf_depth) : 1;
  localparam int c_CW      = $clog2(p_buf_depth + 1);
  localparam int c_NS      = p_net_srcdest_nbits;
  localparam int c_SRC_I   = (p_net_src < p_num_ports) ? p_net_src : 0;
  localparam int c_PLAST_I = p_buf_depth - 1;
  localparam logic [c_NS-1:0] c_SRC       = c_SRC_I[c_NS-1:0];
  localparam logic [c_PW-1:0] c_PTR_LAST  = c_PLAST_I[c_PW-1:0];
  localparam logic [c_CW-1:0] c_DEPTH     = p_buf_depth[c_CW-1:0];
  localparam logic [0:0]      c_ST_IDLE   = 1'b0;
  localparam logic [0:0]      c_ST_SEND   = 1'b1;

  logic [c_CN-1:0]   r_ctrl  [p_buf_depth];
  logic              r_fail  [p_buf_depth];
  logic              r_dom   [p_buf_depth];
  logic              r_burst [p_buf_depth];
  logic [c_LINE-1:0] r_line  [p_buf_depth];

  logic [c_PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic [c_CW-1:0] w_count_next;
  logic [c_IW-1:0] r_idx;
  logic [0:0]      r_state, w_state_next;

  logic w_full, w_push, w_hs, w_last, w_pop, w_scrub;
  logic [c_IW-1:0]               w_last_idx;
  logic [c_CN-1:0]               w_h_ctrl;
  logic                          w_h_fail, w_h_dom, w_h_burst;
  logic [c_LINE-1:0]             w_h_line;
  logic [p_net_opaque_nbits-1:0] w_opq;
  logic [p_data_nbits-1:0]       w_word;

  assign w_full       = (r_count == c_DEPTH);
  assign mem_resp_rdy = reset_n & ~w_full;
  assign w_push       = mem_resp_val & mem_resp_rdy;
  assign w_hs         = net_msg_val & net_msg_rdy;

  assign w_h_ctrl  = r_ctrl[r_rd_ptr];
  assign w_h_fail  = r_fail[r_rd_ptr];
  assign w_h_dom   = r_dom[r_rd_ptr];
  assign w_h_burst = r_burst[r_rd_ptr];
  assign w_h_line  = r_line[r_rd_ptr];

`ifdef PLAB5_MCORE_MEM_NET_RESP_SCRUB_EN
  assign w_scrub = w_h_fail;
`else
  assign w_scrub = 1'b0;
`endif

  // Line size is a power of two, so the final burst index is all ones.
  assign w_last_idx = (w_h_burst & ~w_scrub) ? '1 : '0;
  assign w_last     = (r_idx == w_last_idx);
  assign w_pop      = w_hs & w_last;
  assign w_word     = w_scrub ? '0 : w_h_line[r_idx*p_data_nbits +: p_data_nbits];

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ctrl[r_wr_ptr]  <= mem_resp_control;
      r_fail[r_wr_ptr]  <= mem_resp_fail;
      r_dom[r_wr_ptr]   <= mem_resp_domain;
      r_burst[r_wr_ptr] <= mem_resp_burst;
      r_line[r_wr_ptr]  <= mem_resp_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_idx    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      if (w_pop)     r_idx <= '0;
      else if (w_hs) r_idx <= r_idx + 1'b1;
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + 1'b1;
    else if (!w_push && w_pop) w_count_next = r_count - 1'b1;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= c_ST_IDLE;
    else          r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = c_ST_IDLE;
    if (w_count_next != '0) w_state_next = c_ST_SEND;
  end

  // FSM: outputs, all fields zeroed while no flit is offered
  always_comb begin
    w_opq                = '0;
    w_opq[c_IW-1:0]      = r_idx;
    net_msg_val          = 1'b0;
    net_msg_domain       = 1'b0;
    net_msg_control      = '0;
    net_msg_data         = '0;
    if (r_state == c_ST_SEND) begin
      net_msg_val     = 1'b1;
      net_msg_domain  = w_h_dom;
      net_msg_control = {w_h_ctrl[c_CN-4 -: c_NS], c_SRC, w_opq,
                         w_h_dom, w_h_fail, w_last, w_h_ctrl};
      net_msg_data    = w_word;
    end
  end

endmodule
`default_nettype wire
